// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-port memory between two requesters. m0 is the CPU
//   port and m1 is the loader/DMA port. Each request is latched into a
//   per-port slot, arbitrated, and issued as one registered memory command.
//   Only one command is outstanding at a time. Reads complete with an
//   rvalid pulse. Writes complete when busy drops.
//
//   Parameter RD_LAT (1..4): cycles from the memory command cycle to valid
//   mem_rdata_i.
//
//   Optional feature macro MEM_ARB_RR_EN:
//     undefined : fixed priority, m0 wins a tie.
//     defined   : round-robin, the port not granted last wins a tie.
//
//   Ports
//     clk_i, rst_i             clock, synchronous active-high reset
//     mK_addr_i/rstrb_i/       request bus of port K (K = 0, 1)
//       wmask_i/wdata_i
//     mK_busy_o                slot K occupied
//     mK_rdata_o, mK_rvalid_o  read data, plus a one-cycle completion pulse
//     mem_addr_o/rstrb_o/      registered memory command
//       wmask_o/wdata_o
//     mem_rdata_i              memory read data
//
//   Handshake: port K may present a request (rstrb pulse or nonzero wmask)
//   only in a cycle where mK_busy_o is 0. The request is captured on that
//   edge, and busy stays high until the transfer has completed.
module mem_arbiter #(
   parameter int RD_LAT = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] m0_addr_i,
   input  logic        m0_rstrb_i,
   input  logic [3:0]  m0_wmask_i,
   input  logic [31:0] m0_wdata_i,
   output logic        m0_busy_o,
   output logic [31:0] m0_rdata_o,
   output logic        m0_rvalid_o,
   input  logic [31:0] m1_addr_i,
   input  logic        m1_rstrb_i,
   input  logic [3:0]  m1_wmask_i,
   input  logic [31:0] m1_wdata_i,
   output logic        m1_busy_o,
   output logic [31:0] m1_rdata_o,
   output logic        m1_rvalid_o,
   output logic [31:0] mem_addr_o,
   output logic        mem_rstrb_o,
   output logic [3:0]  mem_wmask_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i
);

   typedef enum logic [1:0] {S_IDLE, S_CMD, S_RD_WAIT} state_t;

   state_t      state_q, state_d;

   // Per-port request slots.
   logic [1:0]  full_q;
   logic [1:0]  rd_q;
   logic [31:0] addr_q  [2];
   logic [3:0]  wmask_q [2];
   logic [31:0] wdata_q [2];

   logic [31:0] rdata_q [2];
   logic [1:0]  rvalid_q;

   logic        cur_q;      // port whose command is in flight
   logic [2:0]  cnt_q;      // read latency countdown

   logic        gnt_vld;
   logic        gnt_idx;

   // Request bus gathered into arrays so both ports share one code path.
   logic [31:0] req_addr  [2];
   logic [3:0]  req_wmask [2];
   logic [31:0] req_wdata [2];
   logic [1:0]  req_vld;

`ifdef MEM_ARB_RR_EN
   logic        ptr_q;      // preferred port on the next tie
`endif

   always_comb begin
      req_addr[0]  = m0_addr_i;
      req_addr[1]  = m1_addr_i;
      req_wmask[0] = m0_wmask_i;
      req_wmask[1] = m1_wmask_i;
      req_wdata[0] = m0_wdata_i;
      req_wdata[1] = m1_wdata_i;
      req_vld[0]   = m0_rstrb_i || (m0_wmask_i != 4'd0);
      req_vld[1]   = m1_rstrb_i || (m1_wmask_i != 4'd0);
   end

   // Next state and grant.
   always_comb begin
      state_d = state_q;
      gnt_vld = 1'b0;
      gnt_idx = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (full_q != 2'b00) begin
               gnt_vld = 1'b1;
               if (full_q == 2'b11) begin
`ifdef MEM_ARB_RR_EN
                  gnt_idx = ptr_q;
`else
                  gnt_idx = 1'b0;
`endif
               end else begin
                  // A lone full slot is the winner.
                  gnt_idx = full_q[1];
               end
               state_d = S_CMD;
            end
         end
         S_CMD: begin
            // A command in flight with rstrb high is a read.
            state_d = mem_rstrb_o ? S_RD_WAIT : S_IDLE;
         end
         S_RD_WAIT: begin
            if (cnt_q == 3'd1) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         full_q      <= '0;
         rd_q        <= '0;
         rvalid_q    <= '0;
         cur_q       <= 1'b0;
         cnt_q       <= '0;
         mem_addr_o  <= '0;
         mem_rstrb_o <= 1'b0;
         mem_wmask_o <= '0;
         mem_wdata_o <= '0;
         for (int k = 0; k < 2; k++) begin
            addr_q[k]  <= '0;
            wmask_q[k] <= '0;
            wdata_q[k] <= '0;
            rdata_q[k] <= '0;
         end
`ifdef MEM_ARB_RR_EN
         ptr_q       <= 1'b0;
`endif
      end else begin
         // Strobes are high for the single CMD cycle only.
         mem_rstrb_o <= 1'b0;
         mem_wmask_o <= '0;
         rvalid_q    <= '0;

         // Capture happens only into an empty slot. A request while busy
         // is dropped. A write wins over a simultaneous read strobe.
         for (int k = 0; k < 2; k++) begin
            if (!full_q[k] && req_vld[k]) begin
               full_q[k]  <= 1'b1;
               rd_q[k]    <= (req_wmask[k] == 4'd0);
               addr_q[k]  <= req_addr[k];
               wmask_q[k] <= req_wmask[k];
               wdata_q[k] <= req_wdata[k];
            end
         end

         if (gnt_vld) begin
            cur_q       <= gnt_idx;
            mem_addr_o  <= addr_q[gnt_idx];
            mem_wdata_o <= wdata_q[gnt_idx];
            mem_rstrb_o <= rd_q[gnt_idx];
            mem_wmask_o <= rd_q[gnt_idx] ? 4'd0 : wmask_q[gnt_idx];
`ifdef MEM_ARB_RR_EN
            ptr_q       <= ~gnt_idx;
`endif
         end

         case (state_q)
            S_CMD: begin
               if (mem_rstrb_o) cnt_q <= 3'(RD_LAT);
               else             full_q[cur_q] <= 1'b0;
            end
            S_RD_WAIT: begin
               // Data is valid in the cycle the counter reads 1.
               if (cnt_q == 3'd1) begin
                  rdata_q[cur_q]  <= mem_rdata_i;
                  rvalid_q[cur_q] <= 1'b1;
                  full_q[cur_q]   <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - 3'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign m0_busy_o   = full_q[0];
   assign m1_busy_o   = full_q[1];
   assign m0_rdata_o  = rdata_q[0];
   assign m1_rdata_o  = rdata_q[1];
   assign m0_rvalid_o = rvalid_q[0];
   assign m1_rvalid_o = rvalid_q[1];

   // Protocol check: a requester must not issue while its slot is busy.
   m0_busy_req_chk: assert property (@(posedge clk_i)
      rst_i || !(full_q[0] && req_vld[0]))
      else $warning("mem_arbiter: m0 request while busy was ignored");
   m1_busy_req_chk: assert property (@(posedge clk_i)
      rst_i || !(full_q[1] && req_vld[1]))
      else $warning("mem_arbiter: m1 request while busy was ignored");

endmodule
